l1d_mshr: RTL and testbench
===========================

Name: l1d_mshr

Overview:
- Miss status holding register block sitting directly upstream of the unified L2 cache.
- Collects L1D line misses, merges duplicate misses to the same line, and issues line-aligned read requests to L2 in allocation order.
- Returns L2 fill data to the L1D tagged with the MSHR entry id.
- Responses from L2 are in order; entries are allocated and retired in FIFO order.

Parameters:
- ENTRIES, 4, number of MSHR entries (power of two, ≥2).
- LINE_OFF, 6, log2 of line size in bytes (64 B lines).
- IDW, $clog2(ENTRIES), entry id width (derived, not overridden).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- miss_valid_i  in  1  L1D miss request
- miss_addr_i  in  64  miss byte address
- miss_ready_o  out  1  miss accepted this cycle when high with miss_valid_i
- miss_id_o  out  IDW  entry id allocated or merged (valid with handshake)
- l2_req_valid_o  out  1  L2 read request
- l2_req_addr_o  out  64  line-aligned request address
- l2_req_ready_i  in  1  L2 accepts request
- l2_resp_valid_i  in  1  L2 response for oldest issued entry
- l2_resp_rdata_i  in  64  response data
- fill_valid_o  out  1  fill to L1D
- fill_addr_o  out  64  line-aligned fill address
- fill_data_o  out  64  fill data
- fill_id_o  out  IDW  entry id being retired
- full_o  out  1  all entries occupied
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_n=0 at posedge):
  - All entries FREE; alloc/issue/retire pointers and occupancy count = 0.
  - fill_valid_o, fill_addr_o, fill_data_o, fill_id_o, err_o = 0.
  - Reset mid-operation discards all entries; no fill is produced for them.
- Entry states: FREE -> PEND on allocation; PEND -> ISSUED on L2 handshake; ISSUED -> FREE on L2 response.
- Line address = addr with bits [LINE_OFF-1:0] cleared. Entries store only the line address.
- Match: combinational compare of miss line against every non-FREE entry. The head entry is excluded when l2_resp_valid_i is high that cycle, because it is retiring.
- miss_ready_o = match | !full_o (combinational; no same-cycle free bypass).
- On a miss handshake:
  - Match: miss_id_o = matching entry id; no allocation. At most one match is possible because merging prevents duplicates.
  - No match: miss_id_o = alloc pointer; that entry becomes PEND at the next edge; alloc pointer and count increment (wrap mod ENTRIES).
- Issue:
  - l2_req_valid_o = (entry[issue_ptr] is PEND), driven from registered state.
  - l2_req_addr_o = that entry's line address.
  - On valid&ready the entry becomes ISSUED and issue_ptr increments.
  - Request is held stable while valid and not ready.
  - A newly allocated entry can be issued no earlier than the cycle after allocation.
- Response:
  - l2_resp_valid_i retires the head entry, which must be ISSUED.
  - Next cycle: fill_valid_o=1 for exactly one cycle, with fill_addr_o = head line, fill_data_o = l2_resp_rdata_i, fill_id_o = head id.
  - The head entry becomes FREE at the same edge; retire pointer increments; count decrements.
  - Latency from response to fill is 1 cycle.
- Response with no ISSUED head entry: ignored; err_o set, held until reset.
- Simultaneous allocate and retire: count unchanged. full_o = (count == ENTRIES), registered.
- Simultaneous issue and response on different entries is legal and both take effect.
- Count never exceeds ENTRIES; pointers wrap at ENTRIES.

Decomposition:
- Package l1d_mshr_pkg holds:
  - mshr_state_e enum {FREE, PEND, ISSUED}.
  - mshr_entry_t struct {state, line_addr}.
  - line_align() function.
  - Default constants MSHR_ENTRIES=4 and LINE_OFF=6.
- One sub-module, l1d_mshr_match: parallel line compare and one-hot-to-id encode, outputting match and match_id.

Test Plan:
- Miss 0x1234 at reset exit -> miss_id_o=0; next cycle l2_req_valid_o=1, addr 0x1200; L2 response data 0xDEAD -> one cycle later fill_valid_o=1, fill_addr_o=0x1200, fill_data_o=0xDEAD, fill_id_o=0.
- Misses 0x1000 then 0x1030 (same line) -> second gets miss_id_o=0 with no new allocation; exactly one L2 request is issued.
- Four distinct-line misses with l2_req_ready_i=0 -> full_o=1; a fifth distinct miss sees miss_ready_o=0; a fifth miss to an already-held line is accepted with the matching id.
- Full queue, response and new distinct miss in the same cycle -> miss not accepted that cycle; accepted the next cycle, receiving the freed id 0.
- l2_resp_valid_i pulse with nothing issued -> no fill_valid_o, err_o=1 sticky; rst_n=0 for one cycle clears err_o and all state.
- Three entries issued, rst_n asserted -> no fills produced, full_o=0, next miss receives id 0.

Source files
------------

// File: rtl/l1d_mshr_pkg.sv
// Shared types and helpers for the L1D miss status holding registers.
package l1d_mshr_pkg;

    localparam int MSHR_ENTRIES = 4;
    localparam int LINE_OFF     = 6;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2
    } mshr_state_e;

    typedef struct packed {
        mshr_state_e state;
        logic [63:0] line_addr;
    } mshr_entry_t;

    // Clear the byte-offset bits so the address names a whole cache line.
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int off);
        logic [63:0] mask;
        mask = ~64'd0 << off;
        return addr & mask;
    endfunction

endpackage

// File: rtl/l1d_mshr_match.sv
// Parallel compare of a miss line against all live entries, with one-hot to id encode.
module l1d_mshr_match
    import l1d_mshr_pkg::*;
#(
    parameter int ENTRIES = MSHR_ENTRIES,
    parameter int IDW     = $clog2(ENTRIES)
) (
    input  mshr_entry_t        entries_i [ENTRIES],
    input  logic [ENTRIES-1:0] exclude_i,
    input  logic [63:0]        miss_line_i,
    output logic               match_o,
    output logic [IDW-1:0]     match_id_o
);

    logic [ENTRIES-1:0] hit;

    // One hit bit per live, non-retiring entry holding the same line.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        hit = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit[i] = (entries_i[i].state != FREE) && !exclude_i[i]
                     && (entries_i[i].line_addr == miss_line_i);
        end
    end

    // Merging keeps lines unique, so at most one bit is set and OR-encoding is exact.
    always_comb begin
        match_id_o = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (hit[i]) match_id_o = match_id_o | IDW'(i);
        end
    end

    assign match_o = |hit;

endmodule

// File: rtl/l1d_mshr.sv
// L1D MSHR: merges duplicate line misses, issues L2 reads in order, returns fills by id.
module l1d_mshr #(
    parameter  int ENTRIES  = l1d_mshr_pkg::MSHR_ENTRIES,
    parameter  int LINE_OFF = l1d_mshr_pkg::LINE_OFF,
    localparam int IDW      = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           miss_valid_i,
    input  logic [63:0]    miss_addr_i,
    output logic           miss_ready_o,
    output logic [IDW-1:0] miss_id_o,
    output logic           l2_req_valid_o,
    output logic [63:0]    l2_req_addr_o,
    input  logic           l2_req_ready_i,
    input  logic           l2_resp_valid_i,
    input  logic [63:0]    l2_resp_rdata_i,
    output logic           fill_valid_o,
    output logic [63:0]    fill_addr_o,
    output logic [63:0]    fill_data_o,
    output logic [IDW-1:0] fill_id_o,
    output logic           full_o,
    output logic           err_o
);

    import l1d_mshr_pkg::*;

    mshr_entry_t        entries_q [ENTRIES];
    mshr_entry_t        entries_d [ENTRIES];
    logic [IDW-1:0]     alloc_ptr_q, alloc_ptr_d;
    logic [IDW-1:0]     issue_ptr_q, issue_ptr_d;
    logic [IDW-1:0]     retire_ptr_q, retire_ptr_d;
    logic [IDW:0]       count_q, count_d;
    logic               full_q, full_d;
    logic               fill_valid_q, fill_valid_d;
    logic [63:0]        fill_addr_q, fill_addr_d;
    logic [63:0]        fill_data_q, fill_data_d;
    logic [IDW-1:0]     fill_id_q, fill_id_d;
    logic               err_q, err_d;

    logic [63:0]        miss_line;
    logic               match;
    logic [IDW-1:0]     match_id;
    logic [ENTRIES-1:0] exclude;
    logic               retire, issue, alloc;

    assign miss_line = line_align(miss_addr_i, LINE_OFF);

    // Only a response hitting an ISSUED head entry actually retires it.
    assign retire = l2_resp_valid_i && (entries_q[retire_ptr_q].state == ISSUED);

    // The retiring head must not absorb a merge, since it is gone after this edge.
    always_comb begin
        exclude               = '0;
        exclude[retire_ptr_q] = retire;
    end

    l1d_mshr_match #(
        .ENTRIES (ENTRIES),
        .IDW     (IDW)
    ) u_match (
        .entries_i   (entries_q),
        .exclude_i   (exclude),
        .miss_line_i (miss_line),
        .match_o     (match),
        .match_id_o  (match_id)
    );

    assign miss_ready_o   = match || !full_q;
    assign miss_id_o      = match ? match_id : alloc_ptr_q;
    assign alloc          = miss_valid_i && miss_ready_o && !match;
    assign l2_req_valid_o = (entries_q[issue_ptr_q].state == PEND);
    assign l2_req_addr_o  = entries_q[issue_ptr_q].line_addr;
    assign issue          = l2_req_valid_o && l2_req_ready_i;

    // Entry array, pointer, occupancy and fill next-state.
    always_comb begin
        entries_d    = entries_q;
        alloc_ptr_d  = alloc_ptr_q  + IDW'(alloc);
        issue_ptr_d  = issue_ptr_q  + IDW'(issue);
        retire_ptr_d = retire_ptr_q + IDW'(retire);
        count_d      = count_q + (IDW+1)'(alloc) - (IDW+1)'(retire);
        full_d       = (count_d == (IDW+1)'(ENTRIES));
        fill_valid_d = retire;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;
        fill_id_d    = fill_id_q;
        err_d        = err_q || (l2_resp_valid_i && !retire);

        if (alloc) begin
            entries_d[alloc_ptr_q].state     = PEND;
            entries_d[alloc_ptr_q].line_addr = miss_line;
        end
        if (issue) begin
            entries_d[issue_ptr_q].state = ISSUED;
        end
        if (retire) begin
            entries_d[retire_ptr_q].state = FREE;
            fill_addr_d = entries_q[retire_ptr_q].line_addr;
            fill_data_d = l2_resp_rdata_i;
            fill_id_d   = retire_ptr_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            // NOTE: only the entry state is reset; line addresses are don't-care while FREE.
            for (int i = 0; i < ENTRIES; i++) entries_q[i].state <= FREE;
            alloc_ptr_q  <= '0;
            issue_ptr_q  <= '0;
            retire_ptr_q <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
            fill_id_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            entries_q    <= entries_d;
            alloc_ptr_q  <= alloc_ptr_d;
            issue_ptr_q  <= issue_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_data_q  <= fill_data_d;
            fill_id_q    <= fill_id_d;
            err_q        <= err_d;
        end
    end

    assign full_o       = full_q;
    assign fill_valid_o = fill_valid_q;
    assign fill_addr_o  = fill_addr_q;
    assign fill_data_o  = fill_data_q;
    assign fill_id_o    = fill_id_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_l1d_mshr.sv
// Self-checking bench for l1d_mshr: directed scenarios plus a randomized run against a queue model.
module tb_l1d_mshr;

    localparam int E = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_valid_i;
    logic [63:0] miss_addr_i;
    logic        miss_ready_o;
    logic [1:0]  miss_id_o;
    logic        l2_req_valid_o;
    logic [63:0] l2_req_addr_o;
    logic        l2_req_ready_i;
    logic        l2_resp_valid_i;
    logic [63:0] l2_resp_rdata_i;
    logic        fill_valid_o;
    logic [63:0] fill_addr_o;
    logic [63:0] fill_data_o;
    logic [1:0]  fill_id_o;
    logic        full_o;
    logic        err_o;

    always #5 clk = ~clk;

    l1d_mshr dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_valid_i    (miss_valid_i),
        .miss_addr_i     (miss_addr_i),
        .miss_ready_o    (miss_ready_o),
        .miss_id_o       (miss_id_o),
        .l2_req_valid_o  (l2_req_valid_o),
        .l2_req_addr_o   (l2_req_addr_o),
        .l2_req_ready_i  (l2_req_ready_i),
        .l2_resp_valid_i (l2_resp_valid_i),
        .l2_resp_rdata_i (l2_resp_rdata_i),
        .fill_valid_o    (fill_valid_o),
        .fill_addr_o     (fill_addr_o),
        .fill_data_o     (fill_data_o),
        .fill_id_o       (fill_id_o),
        .full_o          (full_o),
        .err_o           (err_o)
    );

    int tests_run = 0;
    int failed    = 0;

    // Reference model: outstanding misses in allocation order.
    typedef struct {
        int          id;
        logic [63:0] line;
        bit          issued;
    } ment_t;

    ment_t       mq[$];
    int          next_id;
    bit          m_err;
    bit          m_fv;
    logic [63:0] m_fa, m_fd;
    logic [1:0]  m_fid;

    // Values sampled from the DUT and expected by the model for the cycle just run.
    logic        obs_ready, obs_req_valid, obs_full, obs_fill_valid, obs_err;
    logic [1:0]  obs_id, obs_fill_id;
    logic [63:0] obs_req_addr, obs_fill_addr, obs_fill_data;
    logic        exp_ready, exp_match, exp_req_valid, exp_full, exp_fill_valid, exp_err;
    logic [1:0]  exp_id, exp_fill_id;
    logic [63:0] exp_req_addr, exp_fill_addr, exp_fill_data;

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return {a[63:6], 6'b0};
    endfunction

    task automatic do_reset();
        rst_n           = 1'b0;
        miss_valid_i    = 1'b0;
        miss_addr_i     = '0;
        l2_req_ready_i  = 1'b0;
        l2_resp_valid_i = 1'b0;
        l2_resp_rdata_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        next_id = 0;
        m_err   = 0;
        m_fv    = 0;
        m_fa    = '0;
        m_fd    = '0;
        m_fid   = '0;
    endtask

    // One clock: drive inputs, sample outputs mid-cycle, compute expectations, advance model.
    task automatic cyc(input logic mv, input logic [63:0] ma, input logic rdy,
                       input logic rv, input logic [63:0] rd);
        bit          head_ret;
        int          iss_idx;
        logic [63:0] ml;
        miss_valid_i    = mv;
        miss_addr_i     = ma;
        l2_req_ready_i  = rdy;
        l2_resp_valid_i = rv;
        l2_resp_rdata_i = rd;
        #1;
        obs_ready      = miss_ready_o;
        obs_id         = miss_id_o;
        obs_req_valid  = l2_req_valid_o;
        obs_req_addr   = l2_req_addr_o;
        obs_full       = full_o;
        obs_fill_valid = fill_valid_o;
        obs_fill_addr  = fill_addr_o;
        obs_fill_data  = fill_data_o;
        obs_fill_id    = fill_id_o;
        obs_err        = err_o;

        ml       = line_of(ma);
        head_ret = rv && (mq.size() > 0) && mq[0].issued;
        exp_match = 0;
        exp_id    = 2'(next_id);
        for (int i = 0; i < mq.size(); i++) begin
            if (!(i == 0 && head_ret) && mq[i].line == ml) begin
                exp_match = 1;
                exp_id    = 2'(mq[i].id);
            end
        end
        exp_full  = (mq.size() == E);
        exp_ready = exp_match || !exp_full;
        iss_idx = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].issued && iss_idx < 0) iss_idx = i;
        end
        exp_req_valid  = (iss_idx >= 0);
        exp_req_addr   = (iss_idx >= 0) ? mq[iss_idx].line : '0;
        exp_fill_valid = m_fv;
        exp_fill_addr  = m_fa;
        exp_fill_data  = m_fd;
        exp_fill_id    = m_fid;
        exp_err        = m_err;

        m_fv = 0;
        if (rdy && iss_idx >= 0) mq[iss_idx].issued = 1;
        if (rv) begin
            if (head_ret) begin
                m_fv  = 1;
                m_fa  = mq[0].line;
                m_fd  = rd;
                m_fid = 2'(mq[0].id);
                void'(mq.pop_front());
            end else begin
                m_err = 1;
            end
        end
        if (mv && exp_ready && !exp_match) begin
            mq.push_back('{id: next_id, line: ml, issued: 0});
            next_id = (next_id + 1) % E;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++; if (fill_valid_o !== 1'b0) begin failed++; $display("FAIL reset_fill_valid: got %b want 0", fill_valid_o); end
        tests_run++; if (fill_addr_o !== 64'h0) begin failed++; $display("FAIL reset_fill_addr: got %h want 0", fill_addr_o); end
        tests_run++; if (fill_data_o !== 64'h0) begin failed++; $display("FAIL reset_fill_data: got %h want 0", fill_data_o); end
        tests_run++; if (fill_id_o !== 2'd0) begin failed++; $display("FAIL reset_fill_id: got %0d want 0", fill_id_o); end
        tests_run++; if (err_o !== 1'b0) begin failed++; $display("FAIL reset_err: got %b want 0", err_o); end
        tests_run++; if (full_o !== 1'b0) begin failed++; $display("FAIL reset_full: got %b want 0", full_o); end
        tests_run++; if (l2_req_valid_o !== 1'b0) begin failed++; $display("FAIL reset_req_valid: got %b want 0", l2_req_valid_o); end
        tests_run++; if (miss_ready_o !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b want 1", miss_ready_o); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        cyc(1, 64'h1234, 0, 0, '0);
        tests_run++; if (obs_ready !== 1'b1 || obs_id !== 2'd0) begin failed++; $display("FAIL basic_alloc: ready %b id %0d want 1 0", obs_ready, obs_id); end
        cyc(0, '0, 1, 0, '0);
        tests_run++; if (obs_req_valid !== 1'b1 || obs_req_addr !== 64'h1200) begin failed++; $display("FAIL basic_req: valid %b addr %h want 1 1200", obs_req_valid, obs_req_addr); end
        cyc(0, '0, 0, 1, 64'hDEAD);
        tests_run++; if (obs_fill_valid !== 1'b0) begin failed++; $display("FAIL basic_fill_early: got %b want 0", obs_fill_valid); end
        cyc(0, '0, 0, 0, '0);
        tests_run++; if (obs_fill_valid !== 1'b1 || obs_fill_addr !== 64'h1200 || obs_fill_data !== 64'hDEAD || obs_fill_id !== 2'd0)
            begin failed++; $display("FAIL basic_fill: v %b a %h d %h id %0d want 1 1200 dead 0", obs_fill_valid, obs_fill_addr, obs_fill_data, obs_fill_id); end
        cyc(0, '0, 0, 0, '0);
        tests_run++; if (obs_fill_valid !== 1'b0 || obs_req_valid !== 1'b0) begin failed++; $display("FAIL basic_idle: fill %b req %b want 0 0", obs_fill_valid, obs_req_valid); end
    endtask

    task automatic test_merge();
        int reqs;
        do_reset();
        cyc(1, 64'h1000, 0, 0, '0);
        tests_run++; if (obs_id !== 2'd0) begin failed++; $display("FAIL merge_first_id: got %0d want 0", obs_id); end
        cyc(1, 64'h1030, 0, 0, '0);
        tests_run++; if (obs_ready !== 1'b1 || obs_id !== 2'd0) begin failed++; $display("FAIL merge_second: ready %b id %0d want 1 0", obs_ready, obs_id); end
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, 1, 0, '0);
            if (obs_req_valid === 1'b1) reqs++;
        end
        tests_run++; if (reqs != 1) begin failed++; $display("FAIL merge_req_count: got %0d want 1", reqs); end
        cyc(1, 64'h2000, 0, 0, '0);
        tests_run++; if (obs_id !== 2'd1) begin failed++; $display("FAIL merge_next_alloc: got %0d want 1", obs_id); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 64'(i * 64 + 5), 0, 0, '0);
            tests_run++; if (obs_id !== 2'(i)) begin failed++; $display("FAIL full_alloc_id: got %0d want %0d", obs_id, i); end
        end
        cyc(1, 64'h100, 0, 0, '0);
        tests_run++; if (obs_full !== 1'b1 || obs_ready !== 1'b0) begin failed++; $display("FAIL full_block: full %b ready %b want 1 0", obs_full, obs_ready); end
        cyc(1, 64'h88, 0, 0, '0);
        tests_run++; if (obs_ready !== 1'b1 || obs_id !== 2'd2) begin failed++; $display("FAIL full_merge: ready %b id %0d want 1 2", obs_ready, obs_id); end
        for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, '0);
        cyc(1, 64'h100, 0, 1, 64'hBEEF);
        tests_run++; if (obs_ready !== 1'b0) begin failed++; $display("FAIL full_no_bypass: ready %b want 0", obs_ready); end
        cyc(1, 64'h100, 0, 0, '0);
        tests_run++; if (obs_ready !== 1'b1 || obs_id !== 2'd0) begin failed++; $display("FAIL full_freed_id: ready %b id %0d want 1 0", obs_ready, obs_id); end
        tests_run++; if (obs_fill_valid !== 1'b1 || obs_fill_id !== 2'd0 || obs_fill_data !== 64'hBEEF || obs_fill_addr !== 64'h0)
            begin failed++; $display("FAIL full_fill: v %b id %0d d %h a %h want 1 0 beef 0", obs_fill_valid, obs_fill_id, obs_fill_data, obs_fill_addr); end
    endtask

    task automatic test_err();
        do_reset();
        cyc(0, '0, 0, 1, 64'h55);
        cyc(0, '0, 0, 0, '0);
        tests_run++; if (obs_fill_valid !== 1'b0 || obs_err !== 1'b1) begin failed++; $display("FAIL err_set: fill %b err %b want 0 1", obs_fill_valid, obs_err); end
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0, '0);
        tests_run++; if (obs_err !== 1'b1) begin failed++; $display("FAIL err_sticky: got %b want 1", obs_err); end
        do_reset();
        #1;
        tests_run++; if (err_o !== 1'b0 || full_o !== 1'b0 || l2_req_valid_o !== 1'b0) begin failed++; $display("FAIL err_clear: err %b full %b req %b want 0 0 0", err_o, full_o, l2_req_valid_o); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int fills;
        do_reset();
        cyc(1, 64'h4000, 0, 0, '0);
        cyc(1, 64'h4040, 0, 0, '0);
        cyc(1, 64'h4080, 0, 0, '0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, '0);
        do_reset();
        fills = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, '0, 1, 0, '0);
            if (obs_fill_valid === 1'b1 || obs_req_valid === 1'b1) fills++;
        end
        tests_run++; if (fills != 0) begin failed++; $display("FAIL midreset_activity: got %0d want 0", fills); end
        tests_run++; if (obs_full !== 1'b0) begin failed++; $display("FAIL midreset_full: got %b want 0", obs_full); end
        cyc(1, 64'h9000, 0, 0, '0);
        tests_run++; if (obs_id !== 2'd0) begin failed++; $display("FAIL midreset_id: got %0d want 0", obs_id); end
    endtask

    task automatic test_random();
        logic [63:0] pool [6];
        logic [63:0] addr;
        logic        mv, rdy, rv;
        do_reset();
        for (int i = 0; i < 6; i++) pool[i] = {$urandom, $urandom} & ~64'h3F;
        for (int n = 0; n < 2000; n++) begin
            mv   = 1'($urandom_range(0, 1));
            addr = pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 63));
            rdy  = 1'($urandom_range(0, 1));
            rv   = (mq.size() > 0) && mq[0].issued && ($urandom_range(0, 2) == 0);
            cyc(mv, addr, rdy, rv, {$urandom, $urandom});
            tests_run++; if (obs_ready !== exp_ready) begin failed++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
            tests_run++; if (obs_full !== exp_full) begin failed++; $display("FAIL rnd_full[%0d]: got %b want %b", n, obs_full, exp_full); end
            tests_run++; if (obs_req_valid !== exp_req_valid) begin failed++; $display("FAIL rnd_req_valid[%0d]: got %b want %b", n, obs_req_valid, exp_req_valid); end
            if (exp_req_valid) begin
                tests_run++; if (obs_req_addr !== exp_req_addr) begin failed++; $display("FAIL rnd_req_addr[%0d]: got %h want %h", n, obs_req_addr, exp_req_addr); end
            end
            if (mv && exp_ready) begin
                tests_run++; if (obs_id !== exp_id) begin failed++; $display("FAIL rnd_miss_id[%0d]: got %0d want %0d", n, obs_id, exp_id); end
            end
            tests_run++; if (obs_fill_valid !== exp_fill_valid) begin failed++; $display("FAIL rnd_fill_valid[%0d]: got %b want %b", n, obs_fill_valid, exp_fill_valid); end
            if (exp_fill_valid) begin
                tests_run++; if (obs_fill_addr !== exp_fill_addr || obs_fill_data !== exp_fill_data || obs_fill_id !== exp_fill_id)
                    begin failed++; $display("FAIL rnd_fill[%0d]: a %h d %h id %0d want %h %h %0d", n, obs_fill_addr, obs_fill_data, obs_fill_id, exp_fill_addr, exp_fill_data, exp_fill_id); end
            end
            tests_run++; if (obs_err !== exp_err) begin failed++; $display("FAIL rnd_err[%0d]: got %b want %b", n, obs_err, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_merge();
        test_full();
        test_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
